booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
Control FSM for the sequential Booth multiplier datapath. It loads the operand registers, programs the 4-bit iteration counter, and runs one Booth step per iteration: evaluate, add/sub, arithmetic shift right. It decides when to stop from the counter's zero flag. A start/busy/done/ack handshake faces the issuing unit.

Parameters:
- WIDTH, 8, operand width; also the iteration count loaded into the counter; legal range 1..(2^CNT_W - 1).
- CNT_W, 4, width of the counter load value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- done_ack  in  1  consumer acknowledges the result.
- q0  in  1  datapath Q[0].
- q_m1  in  1  datapath Q[-1] bit.
- cnt_zero  in  1  zero flag from the iteration counter.
- busy  out  1  high in LOAD, EVAL, SHIFT and CHECK.
- done  out  1  result valid; held in DONE.
- ld_regs  out  1  datapath loads M and Q, clears A and Q[-1].
- add_en  out  1  A <= A + M this cycle.
- sub_en  out  1  A <= A - M this cycle.
- shift_en  out  1  arithmetic right shift of {A,Q,Q[-1]}.
- cnt_load  out  1  counter load strobe.
- cnt_load_value  out  CNT_W  constant WIDTH.
- cnt_dec  out  1  counter decrement strobe.

Behaviour:
- Reset: synchronous. While rst=1 at a clock edge, the state goes to IDLE. All 1-bit outputs are 0 after reset. cnt_load_value is always the constant WIDTH.
- Reset mid-operation: the operation is abandoned. IDLE is entered on the next edge, with no done and no further strobes.
- Outputs are decoded from the state. The exception is add_en/sub_en, which also depend on {q0,q_m1} in EVAL.
- IDLE: all outputs 0. start=1 -> LOAD.
- LOAD (1 cycle): ld_regs=1, cnt_load=1, busy=1. Next state is EVAL.
- EVAL (1 cycle): busy=1.
  - {q0,q_m1}=10 -> sub_en=1.
  - {q0,q_m1}=01 -> add_en=1.
  - 00 or 11 -> neither is asserted.
  - add_en and sub_en are never both 1.
  - Next state is SHIFT.
- SHIFT (1 cycle): shift_en=1, cnt_dec=1, busy=1. Next state is CHECK.
- CHECK (1 cycle): busy=1, no strobes. This cycle lets the counter's decremented value appear on cnt_zero.
  - cnt_zero=1 -> DONE.
  - Otherwise -> EVAL.
- DONE: done=1, busy=0.
  - done_ack=1 -> IDLE.
  - start=1 -> LOAD (back-to-back); start has priority over done_ack.
  - done stays asserted until one of these occurs.
- Ignored inputs: start while busy=1 is ignored (no queuing). done_ack outside DONE is ignored.
- Latency (no skip): start sampled at edge 0; LOAD in cycle 1; 3*WIDTH iteration cycles; DONE first visible in cycle 3*WIDTH+2.
- Exactly WIDTH shift_en pulses and WIDTH cnt_dec pulses per operation, and exactly one ld_regs/cnt_load pulse.
- If cnt_zero is already 1 in CHECK before WIDTH shifts have occurred (external fault), the controller still goes to DONE. The controller does not check the iteration count itself.
- Elaboration check: WIDTH must be 1..(2^CNT_W - 1); otherwise a fatal error is raised.

Optional Feature:
- Macro: BOOTH_SKIP_EN.
- Defined: in EVAL with {q0,q_m1} = 00 or 11, EVAL itself asserts shift_en=1 and cnt_dec=1 and goes directly to CHECK, skipping SHIFT. Such an iteration takes 2 cycles instead of 3. Iterations with 10 or 01 are unchanged.
- Undefined: every iteration takes 3 cycles as described above.

Test Plan:
- Baseline timing: WIDTH=8, no macro, bench counter model, q bits held 00, start pulse at cycle 0. Required: LOAD with cnt_load=1 and cnt_load_value=8 in cycle 1; 8 shift_en pulses; done=1 first in cycle 26; add_en/sub_en never asserted.
- Add/sub decode: drive {q0,q_m1}=10 in the first EVAL and 01 in the second. Required: sub_en=1 for exactly one cycle, then add_en=1 for exactly one cycle; never both high; each followed by shift_en in the next cycle.
- Handshake:
  - Hold start=1 throughout busy -> no second LOAD.
  - In DONE with done_ack=0 -> done held for 5 cycles.
  - done_ack=1 -> IDLE next cycle, done=0.
  - start=1 together with done_ack=1 in DONE -> LOAD next cycle.
- Reset mid-operation: assert rst in the third EVAL. Required: the following cycle is IDLE with all outputs 0; a subsequent start yields a full 8-iteration run.
- BOOTH_SKIP_EN defined, WIDTH=8, q bits held 11: each iteration is EVAL (with shift_en and cnt_dec) then CHECK; done first in cycle 18. With bits alternating 10/01: done in cycle 26.

Source files
------------

// File: rtl/booth_seq_ctrl.sv
// Control FSM for the sequential Booth multiplier: load, then EVAL/SHIFT/CHECK per iteration until the counter reports zero.
// Optional macro BOOTH_SKIP_EN folds the shift into EVAL when {q0,q_m1} is 00 or 11.
module booth_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             done_ack,
    input  logic             q0,
    input  logic             q_m1,
    input  logic             cnt_zero,
    output logic             busy,
    output logic             done,
    output logic             ld_regs,
    output logic             add_en,
    output logic             sub_en,
    output logic             shift_en,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_value,
    output logic             cnt_dec
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EVAL  = 3'd2,
        SHIFT = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, next_state;

    if (WIDTH < 1 || WIDTH > (2 ** CNT_W) - 1) begin : g_bad_width
        $fatal(1, "booth_seq_ctrl: WIDTH=%0d does not fit a %0d-bit counter", WIDTH, CNT_W);
    end

    assign cnt_load_value = CNT_W'(WIDTH);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        ld_regs    = 1'b0;
        add_en     = 1'b0;
        sub_en     = 1'b0;
        shift_en   = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    next_state = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                ld_regs    = 1'b1;
                cnt_load   = 1'b1;
                next_state = EVAL;
            end
            EVAL: begin
                busy       = 1'b1;
                next_state = SHIFT;
                case ({q0, q_m1})
                    2'b10:   sub_en = 1'b1;
                    2'b01:   add_en = 1'b1;
                    default: begin
`ifdef BOOTH_SKIP_EN
                        // Nothing to add or subtract, so the shift happens here.
                        shift_en   = 1'b1;
                        cnt_dec    = 1'b1;
                        next_state = CHECK;
`endif
                    end
                endcase
            end
            SHIFT: begin
                busy       = 1'b1;
                shift_en   = 1'b1;
                cnt_dec    = 1'b1;
                next_state = CHECK;
            end
            CHECK: begin
                // Idle cycle so the decremented count reaches cnt_zero.
                busy = 1'b1;
                if (cnt_zero)
                    next_state = DONE;
                else
                    next_state = EVAL;
            end
            DONE: begin
                done = 1'b1;
                if (start)
                    next_state = LOAD;
                else if (done_ack)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: a behavioural counter stands in for the datapath and a
// per-operation timeline built from the Booth rules gives the expected output vector for every cycle.
module tb_booth_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef BOOTH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // Output vector layout: {busy, done, ld_regs, cnt_load, add_en, sub_en, shift_en, cnt_dec}
    localparam logic [7:0] V_IDLE  = 8'b0000_0000;
    localparam logic [7:0] V_LOAD  = 8'b1011_0000;
    localparam logic [7:0] V_EVAL  = 8'b1000_0000;
    localparam logic [7:0] V_ADD   = 8'b0000_1000;
    localparam logic [7:0] V_SUB   = 8'b0000_0100;
    localparam logic [7:0] V_SHDEC = 8'b0000_0011;
    localparam logic [7:0] V_SHIFT = 8'b1000_0011;
    localparam logic [7:0] V_CHECK = 8'b1000_0000;
    localparam logic [7:0] V_DONE  = 8'b0100_0000;

    logic             clk = 1'b0;
    logic             rst, start, done_ack, q0, q_m1, cnt_zero;
    logic             busy, done, ld_regs, add_en, sub_en, shift_en, cnt_load, cnt_dec;
    logic [CNT_W-1:0] cnt_load_value;

    logic [CNT_W-1:0] cnt_m = '1;
    logic             cz_force = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int opn         = 0;

    logic [7:0] exp_q[$];
    logic [1:0] qb_q[$];
    int         evals[$];

    booth_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .done_ack(done_ack),
        .q0(q0), .q_m1(q_m1), .cnt_zero(cnt_zero),
        .busy(busy), .done(done), .ld_regs(ld_regs), .add_en(add_en), .sub_en(sub_en),
        .shift_en(shift_en), .cnt_load(cnt_load), .cnt_load_value(cnt_load_value), .cnt_dec(cnt_dec)
    );

    always #5 clk = ~clk;

    // Iteration counter of the datapath, driven by the controller's strobes.
    always @(posedge clk) begin
        if (cnt_load)
            cnt_m <= cnt_load_value;
        else if (cnt_dec)
            cnt_m <= cnt_m - 1'b1;
    end
    assign cnt_zero = cz_force | (cnt_m == '0);

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [7:0] expv);
        logic [7:0] obs;
        obs = {busy, done, ld_regs, cnt_load, add_en, sub_en, shift_en, cnt_dec};
        vectors++;
        assert (obs === expv && cnt_load_value === CNT_W'(WIDTH)) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b/%0d expected=%b/%0d", tag, obs, cnt_load_value, expv, WIDTH);
        end
    endtask

    // Expected timeline of one operation: LOAD, then per iteration EVAL [SHIFT] CHECK, then DONE.
    function automatic void buildOp(input int iters, input int mode);
        logic [1:0] p;
        logic [7:0] ev;
        bit         quiet;
        exp_q.delete();
        qb_q.delete();
        evals.delete();
        exp_q.push_back(V_LOAD);
        qb_q.push_back(2'($urandom_range(0, 3)));
        for (int k = 0; k < iters; k++) begin
            case (mode)
                1:       p = 2'b00;
                2:       p = (k % 2 == 0) ? 2'b10 : 2'b01;
                3:       p = 2'b11;
                4:       p = (k == 0) ? 2'b10 : (k == 1) ? 2'b01 : 2'($urandom_range(0, 3));
                default: p = 2'($urandom_range(0, 3));
            endcase
            quiet = (p == 2'b00) || (p == 2'b11);
            ev = V_EVAL;
            if (p == 2'b01) ev = ev | V_ADD;
            if (p == 2'b10) ev = ev | V_SUB;
            if (SKIP && quiet) ev = ev | V_SHDEC;
            evals.push_back(exp_q.size());
            exp_q.push_back(ev);
            qb_q.push_back(p);
            if (!(SKIP && quiet)) begin
                exp_q.push_back(V_SHIFT);
                qb_q.push_back(p);
            end
            exp_q.push_back(V_CHECK);
            qb_q.push_back(p);
        end
        exp_q.push_back(V_DONE);
        qb_q.push_back(2'($urandom_range(0, 3)));
    endfunction

    // Caller raises start before the call; returns in the first DONE cycle (or IDLE after an abort).
    task automatic applyStimulus(input int iters, input int mode, input int abort_eval,
                                 input bit hold_start, input bit noisy_ack);
        bit last;
        opn++;
        buildOp(iters, mode);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1 {q0, q_m1} = qb_q[i];
            #1 checkOutput($sformatf("op%0d_cycle%0d", opn, i + 1), exp_q[i]);
            last     = (i == exp_q.size() - 1);
            start    = hold_start && !last;
            done_ack = noisy_ack && !last && ($urandom_range(0, 1) == 1);
            if (abort_eval > 0 && i == evals[abort_eval - 1]) begin
                rst = 1'b1;
                @(posedge clk);
                #2 checkOutput($sformatf("op%0d_reset_mid", opn), V_IDLE);
                rst      = 1'b0;
                start    = 1'b0;
                done_ack = 1'b0;
                return;
            end
        end
    endtask

    task automatic holdDone(input int n);
        start    = 1'b0;
        done_ack = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2 checkOutput("done_hold", V_DONE);
        end
    endtask

    task automatic ackDone();
        done_ack = 1'b1;
        @(posedge clk);
        #2 checkOutput("ack_to_idle", V_IDLE);
        done_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; done_ack = 1'b0; q0 = 1'b0; q_m1 = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #2 checkOutput("reset_idle", V_IDLE);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #2 checkOutput("idle_quiet", V_IDLE);
        done_ack = 1'b1;
        @(posedge clk);
        #2 checkOutput("idle_ack_ignored", V_IDLE);
        done_ack = 1'b0;

        // Baseline: q bits 00, done held five cycles, then acknowledged.
        start = 1'b1;
        applyStimulus(WIDTH, 1, 0, 1'b0, 1'b0);
        holdDone(5);
        ackDone();

        // Subtract then add; start held high and done_ack toggling while busy.
        start = 1'b1;
        applyStimulus(WIDTH, 4, 0, 1'b1, 1'b1);

        // Back-to-back: start wins over done_ack in DONE.
        start = 1'b1; done_ack = 1'b1;
        applyStimulus(WIDTH, 0, 0, 1'b1, 1'b0);
        ackDone();

        // Reset in the third EVAL, then a complete run.
        start = 1'b1;
        applyStimulus(WIDTH, 0, (WIDTH >= 3) ? 3 : 1, 1'b0, 1'b0);
        @(posedge clk);
        #2 checkOutput("post_reset_idle", V_IDLE);
        start = 1'b1;
        applyStimulus(WIDTH, 0, 0, 1'b0, 1'b0);
        ackDone();

        // Counter reports zero early: controller finishes after one iteration.
        cz_force = 1'b1;
        start = 1'b1;
        applyStimulus(1, 0, 0, 1'b0, 1'b0);
        cz_force = 1'b0;
        ackDone();

        for (int r = 0; r < 6; r++) begin
            start = 1'b1;
            applyStimulus(WIDTH, r % 4, 0, (r % 2) == 1, 1'b1);
            holdDone($urandom_range(0, 3));
            ackDone();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
